// File: rtl/spec_free_list_ckpt.sv
// Speculative physical-register free list for rename, with a checkpoint FIFO of head pointers
// for branch mispredict recovery and a full-flush path.
module spec_free_list_ckpt #(
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned PHYS_LOG   = 7,
   parameter int unsigned N_DISP     = 4,
   parameter int unsigned N_COMMIT   = 4,
   parameter int unsigned N_CKPT     = 8,
   parameter int unsigned FIRST_FREE = 32,
   localparam int unsigned PW = $clog2(DEPTH) + 1,
   localparam int unsigned AW = $clog2(N_DISP) + 1,
   localparam int unsigned CW = $clog2(N_CKPT)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         stall_i,
   input  logic [AW-1:0]                alloc_cnt_i,
   output logic [N_DISP*PHYS_LOG-1:0]   free_reg_o,
   output logic [N_DISP-1:0]            free_valid_o,
   output logic                         alloc_stall_o,
   input  logic [N_COMMIT-1:0]          rel_valid_i,
   input  logic [N_COMMIT*PHYS_LOG-1:0] rel_reg_i,
   input  logic                         ckpt_alloc_i,
   output logic [CW-1:0]                ckpt_tag_o,
   output logic                         ckpt_full_o,
   input  logic                         ckpt_rel_i,
   input  logic                         recover_i,
   input  logic [CW-1:0]                recover_tag_i,
   input  logic                         flush_i,
   output logic [PW-1:0]                count_o,
   output logic                         err_o
);
   localparam int unsigned IW = PW - 1;
   localparam int unsigned KW = $clog2(N_COMMIT) + 1;
   localparam int unsigned QW = CW + 1;

   logic [PHYS_LOG-1:0] mem_q    [DEPTH];
   logic [PHYS_LOG-1:0] mem_d    [DEPTH];
   logic [PW-1:0]       ck_mem_q [N_CKPT];
   logic [PW-1:0]       ck_mem_d [N_CKPT];
   logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
   logic [QW-1:0]       ckh_q, ckh_d, ckt_q, ckt_d;
   logic                err_q, err_d;

   logic [PW-1:0]       count, head_pop;
   logic [QW-1:0]       ck_cnt, rec_off;
   logic [KW-1:0]       push;
   logic [IW-1:0]       widx;
   logic                ck_full, ck_empty, pop_en;

   always_comb begin
      count         = tail_q - head_q;
      ck_cnt        = ckt_q - ckh_q;
      ck_full       = (ck_cnt == QW'(N_CKPT));
      ck_empty      = (ck_cnt == '0);
      alloc_stall_o = (PW'(alloc_cnt_i) > count);
      free_reg_o    = '0;
      free_valid_o  = '0;
      for (int i = 0; i < N_DISP; i++) begin
         free_reg_o[i*PHYS_LOG +: PHYS_LOG] = mem_q[head_q[IW-1:0] + IW'(i)];
         free_valid_o[i]                    = (PW'(i) < count);
      end
      count_o     = count;
      ckpt_tag_o  = ckt_q[CW-1:0];
      ckpt_full_o = ck_full;
      err_o       = err_q;
   end

   always_comb begin
      mem_d    = mem_q;
      ck_mem_d = ck_mem_q;
      err_d    = err_q;
      ckh_d    = ckh_q;
      ckt_d    = ckt_q;
      push     = '0;
      widx     = '0;
      // Compact valid release lanes onto consecutive tail slots.
      for (int j = 0; j < N_COMMIT; j++) begin
         if (rel_valid_i[j]) begin
            widx        = tail_q[IW-1:0] + IW'(push);
            mem_d[widx] = rel_reg_i[j*PHYS_LOG +: PHYS_LOG];
            push        = push + KW'(1);
         end
      end
      tail_d = tail_q + PW'(push);
      if ((PW+1)'(count) + (PW+1)'(push) > (PW+1)'(DEPTH)) err_d = 1'b1;

      pop_en   = !stall_i && !alloc_stall_o && !recover_i && !flush_i;
      head_pop = head_q + (pop_en ? PW'(alloc_cnt_i) : '0);
      head_d   = head_pop;
      rec_off  = {1'b0, recover_tag_i - ckh_q[CW-1:0]};

      if (flush_i) begin
         // Same index as tail with opposite wrap bit: every entry is free again.
         head_d = tail_d - PW'(DEPTH);
         ckh_d  = ckt_q;
      end else begin
         if (ckpt_rel_i) begin
            if (ck_empty) err_d = 1'b1;
            else          ckh_d = ckh_q + QW'(1);
         end
         if (recover_i) begin
            if (rec_off < ck_cnt) begin
               head_d = ck_mem_q[recover_tag_i];
               ckt_d  = ckh_q + rec_off + QW'(1);
            end else begin
               err_d = 1'b1;
            end
         end else if (ckpt_alloc_i && !stall_i) begin
            if (ck_full) begin
               err_d = 1'b1;
            end else begin
               ck_mem_d[ckt_q[CW-1:0]] = head_pop;
               ckt_d                   = ckt_q + QW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= PHYS_LOG'(FIRST_FREE + k);
         for (int k = 0; k < N_CKPT; k++) ck_mem_q[k] <= '0;
         head_q <= '0;
         tail_q <= PW'(DEPTH);
         ckh_q  <= '0;
         ckt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         ck_mem_q <= ck_mem_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         ckh_q    <= ckh_d;
         ckt_q    <= ckt_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_spec_free_list_ckpt.sv
// Directed self-checking bench for spec_free_list_ckpt: allocation, stall, release compaction,
// checkpoint/recover, flush, async reset, wrap-around conservation and error flagging.
module tb_spec_free_list_ckpt;
   localparam int PL = 7;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        stall_i, ckpt_alloc_i, ckpt_rel_i, recover_i, flush_i;
   logic [2:0]  alloc_cnt_i, recover_tag_i;
   logic [3:0]  rel_valid_i;
   logic [27:0] rel_reg_i;
   logic [27:0] free_reg_o;
   logic [3:0]  free_valid_o;
   logic        alloc_stall_o, ckpt_full_o, err_o;
   logic [2:0]  ckpt_tag_o;
   logic [6:0]  count_o;

   int n_checks = 0;
   int n_errors = 0;

   spec_free_list_ckpt dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .stall_i       (stall_i),
      .alloc_cnt_i   (alloc_cnt_i),
      .free_reg_o    (free_reg_o),
      .free_valid_o  (free_valid_o),
      .alloc_stall_o (alloc_stall_o),
      .rel_valid_i   (rel_valid_i),
      .rel_reg_i     (rel_reg_i),
      .ckpt_alloc_i  (ckpt_alloc_i),
      .ckpt_tag_o    (ckpt_tag_o),
      .ckpt_full_o   (ckpt_full_o),
      .ckpt_rel_i    (ckpt_rel_i),
      .recover_i     (recover_i),
      .recover_tag_i (recover_tag_i),
      .flush_i       (flush_i),
      .count_o       (count_o),
      .err_o         (err_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      stall_i       = 1'b0;
      alloc_cnt_i   = '0;
      rel_valid_i   = '0;
      rel_reg_i     = '0;
      ckpt_alloc_i  = 1'b0;
      ckpt_rel_i    = 1'b0;
      recover_i     = 1'b0;
      recover_tag_i = '0;
      flush_i       = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
   endtask

   function automatic logic [6:0] lane(input int i);
      return free_reg_o[i*PL +: PL];
   endfunction

   logic [6:0] q[$];
   logic [6:0] newq[$];
   logic [6:0] t;
   bit         in_flight [128];
   int         cnt_m, a, mask;
   bit         grant;

   initial begin
      clr();
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_count", 32'(count_o), 32'd64);
      check_eq("rst_err", 32'(err_o), 32'd0);
      check_eq("rst_astall", 32'(alloc_stall_o), 32'd0);
      check_eq("rst_ctag", 32'(ckpt_tag_o), 32'd0);
      check_eq("rst_cfull", 32'(ckpt_full_o), 32'd0);
      check_eq("rst_fvalid", 32'(free_valid_o), 32'hF);
      reset_n = 1'b1;

      // Two allocations of four.
      alloc_cnt_i = 3'd4;
      #1 check_eq("alloc1_tags", 32'(free_reg_o), 32'({7'd35, 7'd34, 7'd33, 7'd32}));
      cyc();
      check_eq("alloc1_count", 32'(count_o), 32'd60);
      check_eq("alloc2_tags", 32'(free_reg_o), 32'({7'd39, 7'd38, 7'd37, 7'd36}));
      cyc();
      clr();
      check_eq("alloc2_count", 32'(count_o), 32'd56);

      // Checkpoint at head 8, pop 12, checkpoint, pop 4, recover to slot 0 with one release.
      ckpt_alloc_i = 1'b1;
      #1 check_eq("ck0_tag", 32'(ckpt_tag_o), 32'd0);
      cyc();
      clr();
      check_eq("ck0_next", 32'(ckpt_tag_o), 32'd1);
      alloc_cnt_i = 3'd4;
      repeat (3) cyc();
      clr();
      check_eq("pop12_count", 32'(count_o), 32'd44);
      ckpt_alloc_i = 1'b1;
      cyc();
      clr();
      check_eq("ck1_next", 32'(ckpt_tag_o), 32'd2);
      alloc_cnt_i = 3'd4;
      cyc();
      clr();
      check_eq("pop4_count", 32'(count_o), 32'd40);
      recover_i     = 1'b1;
      recover_tag_i = 3'd0;
      alloc_cnt_i   = 3'd4;
      rel_valid_i   = 4'b0001;
      rel_reg_i[6:0] = 7'd5;
      cyc();
      clr();
      check_eq("rec_count", 32'(count_o), 32'd57);
      check_eq("rec_ctag", 32'(ckpt_tag_o), 32'd1);
      check_eq("rec_lane0", 32'(lane(0)), 32'd40);
      check_eq("rec_err", 32'(err_o), 32'd0);
      ckpt_rel_i = 1'b1;
      cyc();
      clr();
      check_eq("ckrel_err", 32'(err_o), 32'd0);

      // Drain to count 2, then stall on 4 and grant 2 across the index wrap.
      alloc_cnt_i = 3'd4;
      repeat (13) cyc();
      alloc_cnt_i = 3'd3;
      cyc();
      clr();
      check_eq("drain_count", 32'(count_o), 32'd2);
      alloc_cnt_i = 3'd4;
      #1 check_eq("astall_on", 32'(alloc_stall_o), 32'd1);
      cyc();
      check_eq("astall_hold", 32'(count_o), 32'd2);
      alloc_cnt_i = 3'd2;
      #1;
      check_eq("astall_off", 32'(alloc_stall_o), 32'd0);
      check_eq("fvalid_2", 32'(free_valid_o), 32'b0011);
      check_eq("wrap_lane0", 32'(lane(0)), 32'd95);
      check_eq("wrap_lane1", 32'(lane(1)), 32'd5);
      cyc();
      clr();
      check_eq("empty_count", 32'(count_o), 32'd0);
      check_eq("fvalid_0", 32'(free_valid_o), 32'd0);

      // Refill four, then pop 4 while releasing on lanes 1 and 3.
      rel_valid_i = 4'hF;
      rel_reg_i   = {7'd13, 7'd12, 7'd11, 7'd10};
      cyc();
      clr();
      check_eq("refill_count", 32'(count_o), 32'd4);
      alloc_cnt_i = 3'd4;
      rel_valid_i = 4'b1010;
      rel_reg_i   = {7'd9, 7'd2, 7'd5, 7'd1};
      #1 check_eq("refill_tags", 32'(free_reg_o), 32'({7'd13, 7'd12, 7'd11, 7'd10}));
      cyc();
      clr();
      check_eq("poppush_count", 32'(count_o), 32'd2);
      check_eq("compact_tags", 32'(free_reg_o[13:0]), 32'({7'd9, 7'd5}));

      // Three live checkpoints, then flush with pending alloc, ckpt alloc and a release.
      ckpt_alloc_i = 1'b1;
      repeat (3) cyc();
      clr();
      check_eq("ck3_tag", 32'(ckpt_tag_o), 32'd4);
      flush_i        = 1'b1;
      alloc_cnt_i    = 3'd2;
      ckpt_alloc_i   = 1'b1;
      rel_valid_i    = 4'b0001;
      rel_reg_i[6:0] = 7'd20;
      cyc();
      clr();
      check_eq("flush_count", 32'(count_o), 32'd64);
      check_eq("flush_cfull", 32'(ckpt_full_o), 32'd0);
      check_eq("flush_ctag", 32'(ckpt_tag_o), 32'd4);
      check_eq("flush_err", 32'(err_o), 32'd0);
      check_eq("flush_lane0", 32'(lane(0)), 32'd40);
      ckpt_alloc_i = 1'b1;
      repeat (8) cyc();
      clr();
      check_eq("ckfull", 32'(ckpt_full_o), 32'd1);
      check_eq("ckfull_tag", 32'(ckpt_tag_o), 32'd4);

      // Asynchronous reset mid-cycle.
      do_reset();
      check_eq("mrst_count", 32'(count_o), 32'd64);
      check_eq("mrst_cfull", 32'(ckpt_full_o), 32'd0);
      check_eq("mrst_ctag", 32'(ckpt_tag_o), 32'd0);
      check_eq("mrst_lane0", 32'(lane(0)), 32'd32);
      check_eq("mrst_fvalid", 32'(free_valid_o), 32'hF);
      @(negedge clk);
      reset_n = 1'b1;

      // Random pops and releases over many wraps: count conserved, tags never duplicated.
      cnt_m = 64;
      for (int c = 0; c < 400; c++) begin
         a    = $urandom_range(0, 4);
         mask = $urandom_range(0, 15);
         clr();
         alloc_cnt_i = 3'(a);
         for (int j = 0; j < 4; j++) begin
            if (mask[j] && q.size() > 0) begin
               t = q.pop_front();
               in_flight[t] = 1'b0;
               rel_valid_i[j] = 1'b1;
               rel_reg_i[j*PL +: PL] = t;
               cnt_m++;
            end
         end
         #1;
         grant = (a <= cnt_m - $countones(rel_valid_i));
         if (alloc_stall_o !== !grant) check_eq("rnd_astall", 32'(alloc_stall_o), 32'(!grant));
         if (grant) begin
            for (int i = 0; i < a; i++) begin
               t = lane(i);
               if (in_flight[t] || t < 7'd32) check_eq("rnd_uniq", 32'(t), 32'hFFFF);
               in_flight[t] = 1'b1;
               newq.push_back(t);
            end
            cnt_m -= a;
         end
         cyc();
         if (c % 16 == 15) check_eq("rnd_count", 32'(count_o), 32'(cnt_m));
         while (newq.size() > 0) q.push_back(newq.pop_front());
      end
      clr();
      check_eq("rnd_count_end", 32'(count_o), 32'(cnt_m));
      check_eq("rnd_err", 32'(err_o), 32'd0);

      // Release on an empty checkpoint FIFO.
      ckpt_rel_i = 1'b1;
      cyc();
      clr();
      check_eq("ckrel_empty_err", 32'(err_o), 32'd1);

      // Recover to a dead slot is ignored and flagged; a live slot still restores.
      do_reset();
      check_eq("rst2_err", 32'(err_o), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      ckpt_alloc_i = 1'b1;
      alloc_cnt_i  = 3'd4;
      cyc();
      ckpt_alloc_i = 1'b0;
      cyc();
      clr();
      check_eq("pre_rec_count", 32'(count_o), 32'd56);
      recover_i     = 1'b1;
      recover_tag_i = 3'd2;
      cyc();
      clr();
      check_eq("badrec_err", 32'(err_o), 32'd1);
      check_eq("badrec_count", 32'(count_o), 32'd56);
      recover_i     = 1'b1;
      recover_tag_i = 3'd0;
      cyc();
      clr();
      check_eq("goodrec_count", 32'(count_o), 32'd60);
      check_eq("goodrec_ctag", 32'(ckpt_tag_o), 32'd1);

      // Overflow: release into a full list.
      do_reset();
      @(negedge clk);
      reset_n = 1'b1;
      rel_valid_i    = 4'b0001;
      rel_reg_i[6:0] = 7'd7;
      cyc();
      clr();
      check_eq("ovf_err", 32'(err_o), 32'd1);
      check_eq("ovf_count", 32'(count_o), 32'd65);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
